matrix_loader_4x4: RTL and testbench

Upstream feeder for the 4x4 matrix multiplier. It accepts a byte stream of 32 elements over a valid/ready handshake: matrix A first, then matrix B, each in row-major order. It assembles both operands into flat holding registers, issues a one-cycle start pulse, and holds the operands stable until the multiplier reports done. Only then does it accept the next frame.

---
 rtl/matrix_loader_4x4.sv | 114 +++++++++++
 tb/tb_matrix_loader_4x4.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_loader_4x4.sv
// Operand loader for the 4x4 matrix multiplier: gathers 32 bytes (A then B, row-major),
// pulses mm_start, then holds the operands until mm_done rises. Optional macro: LOADER_LEN_CHECK_EN.
module matrix_loader_4x4 #(
    parameter int DW = 8,
    parameter int N  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    input  logic                in_last,
    output logic [N*N*DW-1:0]   a_flat,
    output logic [N*N*DW-1:0]   b_flat,
    output logic                mm_start,
    input  logic                mm_done,
    output logic                busy,
    output logic [7:0]          frame_cnt,
    output logic                err_len
);

    localparam logic [4:0] LAST_IDX = 5'(2*N*N - 1);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [4:0] idx;
    logic [3:0] slot;
    logic       done_q;
    logic       accept;
    logic       len_err;

    assign accept = in_valid && in_ready;
    assign slot   = idx[3:0];

`ifdef LOADER_LEN_CHECK_EN
    // A frame whose in_last marker disagrees with the element count is dropped.
    assign len_err = accept && (in_last != (idx == LAST_IDX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_len <= 1'b0;
        end else if (len_err) begin
            err_len <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = in_last;
    assign len_err     = 1'b0;
    assign err_len     = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            FILL:    if (accept && (idx == LAST_IDX) && !len_err) next_state = LAUNCH;
            LAUNCH:  next_state = WAIT;
            WAIT:    if (mm_done && !done_q) next_state = FILL;
            default: next_state = FILL;
        endcase
    end

    assign in_ready = (state == FILL) && !rst;
    assign busy     = (state == LAUNCH) || (state == WAIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            mm_start  <= 1'b0;
            frame_cnt <= '0;
            done_q    <= 1'b1;
        end else begin
            state    <= next_state;
            mm_start <= (next_state == LAUNCH);
            if (accept) begin
                if (len_err || (idx == LAST_IDX)) begin
                    idx <= '0;
                end else begin
                    idx <= idx + 5'd1;
                end
            end
            if (state == LAUNCH) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            // done_q starts high on entering WAIT so a level left over from the last run is not an edge.
            if (state == LAUNCH) begin
                done_q <= 1'b1;
            end else if (state == WAIT) begin
                done_q <= mm_done;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_flat <= '0;
            b_flat <= '0;
        end else if (accept) begin
            if (idx[4]) begin
                b_flat[slot*DW +: DW] <= in_data;
            end else begin
                a_flat[slot*DW +: DW] <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_matrix_loader_4x4.sv
// Scoreboard testbench for matrix_loader_4x4: random frames against an array-based model,
// plus backpressure, stale-done, reset, length-check and frame counter wrap scenarios.
module tb_matrix_loader_4x4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         in_last;
    logic [127:0] a_flat;
    logic [127:0] b_flat;
    logic         mm_start;
    logic         mm_done;
    logic         busy;
    logic [7:0]   frame_cnt;
    logic         err_len;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic [7:0]   cnt;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] ma[16];
    logic [7:0] mb[16];
    int         mIdx;
    int         mCount;

    matrix_loader_4x4 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .a_flat(a_flat), .b_flat(b_flat),
        .mm_start(mm_start), .mm_done(mm_done), .busy(busy),
        .frame_cnt(frame_cnt), .err_len(err_len)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] packA();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = ma[i];
        return r;
    endfunction

    function automatic logic [127:0] packB();
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = mb[i];
        return r;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            ma[i] = 8'd0;
            mb[i] = 8'd0;
        end
        mIdx   = 0;
        mCount = 0;
    endtask

    // Reference behaviour of one accepted element, straight from the frame rules.
    task automatic modelAccept(input logic [7:0] d, input logic last);
        bit bad;
`ifdef LOADER_LEN_CHECK_EN
        bad = (last != (mIdx == 31));
`else
        bad = 1'b0;
`endif
        if (mIdx < 16) ma[mIdx] = d;
        else           mb[mIdx-16] = d;
        if (bad) begin
            mIdx = 0;
        end else if (mIdx == 31) begin
            mIdx   = 0;
            mCount = (mCount + 1) % 256;
            expQ.push_back('{packA(), packB(), 8'(mCount)});
        end else begin
            mIdx++;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic last, input int gap);
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom_range(0, 255));
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        checkOutput("in_ready_fill", 128'(in_ready), 128'(1));
        @(posedge clk);
        modelAccept(d, last);
    endtask

    // kind 0 = identity/ramp frame, 1 = random; gapMode 0 none, 1 alternate, 2 random.
    task automatic sendFrame(input int kind, input int gapMode);
        logic [7:0] d;
        logic       last;
        int         gap;
        for (int i = 0; i < 32; i++) begin
            if (kind == 0) d = (i < 16) ? ((i % 5 == 0) ? 8'd1 : 8'd0) : 8'(i - 16);
            else           d = 8'($urandom_range(0, 255));
`ifdef LOADER_LEN_CHECK_EN
            last = (i == 31);
`else
            last = 1'($urandom_range(0, 1));
`endif
            gap = (gapMode == 1) ? 1 : (gapMode == 2) ? int'($urandom_range(0, 1)) : 0;
            applyStimulus(d, last, gap);
        end
    endtask

    task automatic ackDone(input int latency, input bit holdValid);
        @(negedge clk);
        in_valid = holdValid;
        in_data  = 8'hFF;
        checkOutput("start_launch", 128'(mm_start), 128'(1));
        checkOutput("busy_launch", 128'(busy), 128'(1));
        for (int k = 0; k < latency; k++) begin
            @(negedge clk);
            checkOutput("ready_wait", 128'(in_ready), 128'(0));
            if (holdValid) begin
                checkOutput("a_hold", a_flat, packA());
                checkOutput("b_hold", b_flat, packB());
            end
        end
        in_valid = 1'b0;
        mm_done  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("ready_after_done", 128'(in_ready), 128'(1));
        checkOutput("busy_after_done", 128'(busy), 128'(0));
        mm_done = 1'b0;
    endtask

    task automatic checkReset();
        checkOutput("rst_in_ready", 128'(in_ready), 128'(0));
        checkOutput("rst_a_flat", a_flat, 128'(0));
        checkOutput("rst_b_flat", b_flat, 128'(0));
        checkOutput("rst_mm_start", 128'(mm_start), 128'(0));
        checkOutput("rst_busy", 128'(busy), 128'(0));
        checkOutput("rst_frame_cnt", 128'(frame_cnt), 128'(0));
        checkOutput("rst_err_len", 128'(err_len), 128'(0));
    endtask

    // Monitor: every start pulse is matched against the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && mm_start) begin
                if (expQ.size() == 0) begin
                    checks++;
                    fails++;
                    $display("[TB] FAIL unexpected_start: got mm_start=1 expected no launch");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb_a_flat", a_flat, e.a);
                    checkOutput("sb_b_flat", b_flat, e.b);
                    @(negedge clk);
                    checkOutput("sb_start_width", 128'(mm_start), 128'(0));
                    checkOutput("sb_frame_cnt", 128'(frame_cnt), 128'(e.cnt));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [127:0] idA;
        int           wrapStart;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'd0;
        in_last  = 1'b0;
        mm_done  = 1'b0;
        modelReset();
        #12;
        checkReset();
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] identity frame");
        sendFrame(0, 0);
        idA = 128'h01000000_00010000_00000100_00000001;
        checkOutput("identity_model", packA(), idA);
        ackDone(3, 1'b0);
        checkOutput("identity_cnt", 128'(frame_cnt), 128'(1));

        $display("[TB] backpressure hold");
        sendFrame(1, 0);
        ackDone(20, 1'b1);

        $display("[TB] stale done");
        mm_done = 1'b1;
        sendFrame(1, 2);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            checkOutput("stale_ready", 128'(in_ready), 128'(0));
        end
        mm_done = 1'b0;
        @(negedge clk);
        checkOutput("stale_low_ready", 128'(in_ready), 128'(0));
        mm_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("stale_rise_ready", 128'(in_ready), 128'(1));
        mm_done = 1'b0;

        $display("[TB] bubbles and reset");
        for (int i = 0; i < 10; i++) applyStimulus(8'($urandom_range(0, 255)), 1'b0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        modelReset();
        #1;
        checkReset();
        @(negedge clk);
        rst = 1'b0;
        sendFrame(1, 1);
        ackDone(4, 1'b0);

`ifdef LOADER_LEN_CHECK_EN
        $display("[TB] length check");
        for (int i = 0; i < 6; i++) applyStimulus(8'($urandom_range(0, 255)), (i == 5), 0);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("len_err_set", 128'(err_len), 128'(1));
        checkOutput("len_still_fill", 128'(in_ready), 128'(1));
        sendFrame(1, 0);
        ackDone(3, 1'b0);
        checkOutput("len_err_sticky", 128'(err_len), 128'(1));
`else
        checkOutput("err_len_tied", 128'(err_len), 128'(0));
`endif

        $display("[TB] frame counter wrap");
        wrapStart = mCount;
        for (int f = 0; f < 256; f++) begin
            sendFrame(1, 2);
            ackDone($urandom_range(2, 5), 1'b0);
        end
        checkOutput("wrap_cnt", 128'(frame_cnt), 128'(wrapStart));

        repeat (3) @(negedge clk);
        checkOutput("pending_starts", 128'(expQ.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
